// File: rtl/rooth_test_monitor_pkg.sv
// Shared types and constants for the rooth_soc instruction-test monitor.
package rooth_test_monitor_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [2:0] {
        TM_IDLE,
        TM_CORE_RST,
        TM_RUN,
        TM_CHECK,
        TM_FINISH
    } tm_state_e;

endpackage

// File: rtl/rooth_wb_snoop.sv
// Snoops register-file write-back: keeps pass/test-number shadows and flags the done write.
module rooth_wb_snoop
    import rooth_test_monitor_pkg::*;
#(
    parameter int unsigned CPU_WIDTH = 32,
    parameter int unsigned DONE_REG  = 26,
    parameter int unsigned PASS_REG  = 27,
    parameter int unsigned TNUM_REG  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  en,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [CPU_WIDTH-1:0]  wb_data,
    output logic                  pass_flag,
    output logic [CPU_WIDTH-1:0]  tnum,
    output logic                  done_c
);

    logic wr_ok_c;

    // x0 is hard-wired to zero in the core, so writes to it never carry information
    assign wr_ok_c = en && wb_we && (wb_addr != '0);
    assign done_c  = wr_ok_c && (wb_addr == REG_ADDR_W'(DONE_REG))
                     && (wb_data == CPU_WIDTH'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_flag <= 1'b0;
            tnum      <= '0;
        end else if (clear) begin
            pass_flag <= 1'b0;
            tnum      <= '0;
        end else if (wr_ok_c) begin
            if (wb_addr == REG_ADDR_W'(PASS_REG)) begin
                pass_flag <= (wb_data == CPU_WIDTH'(1));
            end
            if (wb_addr == REG_ADDR_W'(TNUM_REG)) begin
                tnum <= wb_data;
            end
        end
    end

endmodule

// File: rtl/rooth_test_monitor.sv
// Sequences TEST_NUM core runs, judges each from write-back snooping and reports status.
module rooth_test_monitor
    import rooth_test_monitor_pkg::*;
#(
    parameter int unsigned CPU_WIDTH    = 32,
    parameter int unsigned TEST_NUM     = 45,
    parameter int unsigned IDX_W        = 6,
    parameter int unsigned DONE_REG     = 26,
    parameter int unsigned PASS_REG     = 27,
    parameter int unsigned TNUM_REG     = 3,
    parameter int unsigned RST_CYC      = 2,
    parameter int unsigned TIMEOUT_CYC  = 50000,
    parameter int unsigned TO_W         = 16,
    parameter int unsigned STOP_ON_FAIL = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  wb_we_i,
    input  logic [REG_ADDR_W-1:0] wb_addr_i,
    input  logic [CPU_WIDTH-1:0]  wb_data_i,
    output logic                  core_rst_n_o,
    output logic [IDX_W-1:0]      test_idx_o,
    output logic                  test_done_o,
    output logic                  test_pass_o,
    output logic [IDX_W-1:0]      fail_cnt_o,
    output logic [IDX_W-1:0]      fail_idx_o,
    output logic [CPU_WIDTH-1:0]  fail_tnum_o,
    output logic                  timeout_o,
    output logic                  busy_o,
    output logic                  all_done_o,
    output logic                  all_pass_o
);

    localparam int unsigned RST_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    tm_state_e            state;
    logic [RST_W-1:0]     rst_cnt;
    logic [TO_W-1:0]      to_cnt;
    logic                 pass_flag;
    logic [CPU_WIDTH-1:0] tnum;
    logic                 done_c;
    logic                 run_end_c;
    logic                 run_pass_c;
    logic                 stop_c;

    rooth_wb_snoop #(
        .CPU_WIDTH (CPU_WIDTH),
        .DONE_REG  (DONE_REG),
        .PASS_REG  (PASS_REG),
        .TNUM_REG  (TNUM_REG)
    ) u_snoop (
        .clk       (clk),
        .rst       (rst),
        .clear     (state == TM_CORE_RST),
        .en        (state == TM_RUN),
        .wb_we     (wb_we_i),
        .wb_addr   (wb_addr_i),
        .wb_data   (wb_data_i),
        .pass_flag (pass_flag),
        .tnum      (tnum),
        .done_c    (done_c)
    );

    // A done write in the last allowed cycle beats the timeout
    assign run_end_c  = done_c || (to_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign run_pass_c = done_c && pass_flag;
    assign stop_c     = (!test_pass_o && (STOP_ON_FAIL != 0))
                        || (test_idx_o == IDX_W'(TEST_NUM - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= TM_IDLE;
            rst_cnt      <= '0;
            to_cnt       <= '0;
            core_rst_n_o <= 1'b0;
            test_idx_o   <= '0;
            test_done_o  <= 1'b0;
            test_pass_o  <= 1'b0;
            fail_cnt_o   <= '0;
            fail_idx_o   <= '0;
            fail_tnum_o  <= '0;
            timeout_o    <= 1'b0;
            busy_o       <= 1'b0;
            all_done_o   <= 1'b0;
            all_pass_o   <= 1'b0;
        end else begin
            test_done_o <= 1'b0;
            case (state)
                TM_IDLE, TM_FINISH: begin
                    if (start_i) begin
                        state       <= TM_CORE_RST;
                        rst_cnt     <= '0;
                        busy_o      <= 1'b1;
                        test_idx_o  <= '0;
                        fail_cnt_o  <= '0;
                        fail_idx_o  <= '0;
                        fail_tnum_o <= '0;
                        timeout_o   <= 1'b0;
                        all_done_o  <= 1'b0;
                        all_pass_o  <= 1'b0;
                    end
                end
                TM_CORE_RST: begin
                    to_cnt <= '0;
                    if (rst_cnt == RST_W'(RST_CYC - 1)) begin
                        state        <= TM_RUN;
                        core_rst_n_o <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt + RST_W'(1);
                    end
                end
                TM_RUN: begin
                    if (run_end_c) begin
                        state        <= TM_CHECK;
                        core_rst_n_o <= 1'b0;
                        test_done_o  <= 1'b1;
                        test_pass_o  <= run_pass_c;
                        if (!done_c) begin
                            timeout_o <= 1'b1;
                        end
                        // Counter still zero means this is the first failure of the sequence
                        if (!run_pass_c) begin
                            if (fail_cnt_o != '1) begin
                                fail_cnt_o <= fail_cnt_o + IDX_W'(1);
                            end
                            if (fail_cnt_o == '0) begin
                                fail_idx_o  <= test_idx_o;
                                fail_tnum_o <= tnum;
                            end
                        end
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                TM_CHECK: begin
                    if (stop_c) begin
                        state      <= TM_FINISH;
                        busy_o     <= 1'b0;
                        all_done_o <= 1'b1;
                        all_pass_o <= (fail_cnt_o == '0);
                    end else begin
                        state      <= TM_CORE_RST;
                        rst_cnt    <= '0;
                        test_idx_o <= test_idx_o + IDX_W'(1);
                    end
                end
                default: state <= TM_IDLE;
            endcase
        end
    end

endmodule
